// File: rtl/exc_pipe_ctrl.sv
// exc_pipe_ctrl - exception pipeline controller in front of CP0.
// Tracks pc / delay-slot flag / exception code / eret through the D, E and M
// stage registers. Causes are resolved first-detected-wins, and one ExcCode
// per instruction is presented at M. The controller turns CP0's req (or a
// retiring ERET) into a pipeline flush and a fetch redirect.
// Optional build macro: EXC_PERF_CNT_EN adds saturating exception and
// interrupt counters on the exc_cnt / int_cnt ports.
module exc_pipe_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_D,
  input  logic [31:0] pc_F,
  input  logic        ri_D,
  input  logic        syscall_D,
  input  logic        break_D,
  input  logic        eret_D,
  input  logic        jump_D,
  input  logic        ov_E,
  input  logic        adel_E,
  input  logic        ades_E,
  input  logic        req,
  input  logic [31:0] epc,
  output logic [4:0]  ExcCode_M,
  output logic        bd_M,
  output logic [31:0] pc_M,
  output logic        EXLClr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
`ifdef EXC_PERF_CNT_EN
  ,
  output logic [15:0] exc_cnt,
  output logic [15:0] int_cnt
`endif
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // Exception codes, matching cpu_def.vh
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic        eret;
  } stage_t;

  function automatic stage_t bubble(input logic [31:0] pc, input logic bd);
    stage_t b;
    b.pc   = pc;
    b.bd   = bd;
    b.code = EXC_NONE;
    b.eret = 1'b0;
    return b;
  endfunction

  stage_t d_q, d_d;
  stage_t e_q, e_d;
  stage_t m_q, m_d;

  stage_t f_res;
  stage_t d_res;
  stage_t e_res;

  logic        exl_clr;
  logic        flush_int;
  logic [31:0] target_pc;

  // F: misaligned fetch address; the instruction behind a jump in D is a delay slot
  always_comb begin
    f_res.pc   = pc_F;
    f_res.bd   = jump_D;
    f_res.code = (pc_F[1:0] != 2'b00) ? EXC_ADEL : EXC_NONE;
    f_res.eret = 1'b0;
  end

  // D: decode causes apply only when nothing was detected earlier
  always_comb begin
    d_res = d_q;
    if (d_q.code == EXC_NONE) begin
      if (ri_D)           d_res.code = EXC_RI;
      else if (syscall_D) d_res.code = EXC_SYS;
      else if (break_D)   d_res.code = EXC_BP;
    end
    d_res.eret = eret_D && (d_res.code == EXC_NONE);
  end

  // E: execute/memory causes apply only when nothing was detected earlier
  always_comb begin
    e_res = e_q;
    if (e_q.code == EXC_NONE) begin
      if (ov_E)        e_res.code = EXC_OV;
      else if (adel_E) e_res.code = EXC_ADEL;
      else if (ades_E) e_res.code = EXC_ADES;
    end
    e_res.eret = e_q.eret && (e_res.code == EXC_NONE);
  end

  // Redirect decision: a CP0 request beats a retiring ERET
  always_comb begin
    exl_clr   = m_q.eret && (m_q.code == EXC_NONE) && !req;
    flush_int = req || exl_clr;
    target_pc = exl_clr ? epc : HANDLER_PC;
  end

  // Stage advance: flush beats stall; a stall sends a bubble carrying D's pc/bd into E
  always_comb begin
    d_d = d_q;
    e_d = e_q;
    m_d = e_res;
    if (flush_int) begin
      d_d = bubble(target_pc, 1'b0);
      e_d = bubble(target_pc, 1'b0);
      m_d = bubble(target_pc, 1'b0);
    end else if (stall_D) begin
      e_d = bubble(d_q.pc, d_q.bd);
    end else begin
      d_d = f_res;
      e_d = d_res;
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q <= bubble(RESET_PC, 1'b0);
      e_q <= bubble(RESET_PC, 1'b0);
      m_q <= bubble(RESET_PC, 1'b0);
    end else begin
      d_q <= d_d;
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  assign ExcCode_M   = m_q.code;
  assign bd_M        = m_q.bd;
  assign pc_M        = m_q.pc;
  assign EXLClr      = exl_clr;
  assign flush       = flush_int;
  assign redirect    = flush_int;
  assign redirect_pc = target_pc;

`ifdef EXC_PERF_CNT_EN
  logic [15:0] exc_cnt_q, exc_cnt_d;
  logic [15:0] int_cnt_q, int_cnt_d;

  // Count taken exceptions vs interrupts (code 0 at M), saturating
  always_comb begin
    exc_cnt_d = exc_cnt_q;
    int_cnt_d = int_cnt_q;
    if (req) begin
      if (m_q.code != EXC_NONE) begin
        if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 16'd1;
      end else begin
        if (int_cnt_q != '1) int_cnt_d = int_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_cnt_q <= '0;
      int_cnt_q <= '0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
      int_cnt_q <= int_cnt_d;
    end
  end

  assign exc_cnt = exc_cnt_q;
  assign int_cnt = int_cnt_q;
`endif

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Scoreboard bench for exc_pipe_ctrl. The reference model tracks whole
// instructions (each with the set of causes observed along the way) and
// derives ExcCode from the priority list at M; expectations are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_exc_pipe_ctrl;

  localparam logic [31:0] HANDLER = 32'hBFC0_0380;
  localparam logic [31:0] RST_PC  = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_D;
  logic [31:0] pc_F;
  logic        ri_D, syscall_D, break_D, eret_D, jump_D;
  logic        ov_E, adel_E, ades_E;
  logic        req;
  logic [31:0] epc;
  logic [4:0]  ExcCode_M;
  logic        bd_M;
  logic [31:0] pc_M;
  logic        EXLClr, flush, redirect;
  logic [31:0] redirect_pc;
`ifdef EXC_PERF_CNT_EN
  logic [15:0] exc_cnt, int_cnt;
`endif

  always #5 clk = ~clk;

  exc_pipe_ctrl #(.HANDLER_PC(HANDLER)) dut (
    .clk(clk), .resetn(resetn), .stall_D(stall_D), .pc_F(pc_F),
    .ri_D(ri_D), .syscall_D(syscall_D), .break_D(break_D), .eret_D(eret_D),
    .jump_D(jump_D), .ov_E(ov_E), .adel_E(adel_E), .ades_E(ades_E),
    .req(req), .epc(epc), .ExcCode_M(ExcCode_M), .bd_M(bd_M), .pc_M(pc_M),
    .EXLClr(EXLClr), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef EXC_PERF_CNT_EN
    , .exc_cnt(exc_cnt), .int_cnt(int_cnt)
`endif
  );

  // One instruction in flight, with every cause it has seen so far
  typedef struct {
    logic [31:0] pc;
    bit bd, f_adel, ri, sys, bp, eret, ov, adel, ades;
  } instr_t;

  typedef struct {
    bit stall;
    logic [31:0] pc_f;
    bit ri, sys, bp, eret, jump, ov, adel, ades, req;
    logic [31:0] epc;
  } stim_t;

  typedef struct {
    logic [4:0]  code;
    bit          bd;
    logic [31:0] pc;
    bit          exl, flush, redirect;
    logic [31:0] rpc;
    logic [15:0] ec, ic;
  } exp_t;

  instr_t pipe [3];  // 0 = D, 1 = E, 2 = M
  exp_t   sbq [$];
  exp_t   mon_e;
  logic [15:0] m_exc, m_int;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic instr_t blank(input logic [31:0] pc, input bit bd);
    instr_t r;
    r.pc = pc; r.bd = bd; r.f_adel = 0; r.ri = 0; r.sys = 0; r.bp = 0;
    r.eret = 0; r.ov = 0; r.adel = 0; r.ades = 0;
    return r;
  endfunction

  // First cause in pipeline order wins; within a stage the listed priority applies
  function automatic logic [4:0] cause(input instr_t i);
    if (i.f_adel) return 5'd4;
    if (i.ri)     return 5'd10;
    if (i.sys)    return 5'd8;
    if (i.bp)     return 5'd9;
    if (i.ov)     return 5'd12;
    if (i.adel)   return 5'd4;
    if (i.ades)   return 5'd5;
    return 5'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = blank(RST_PC, 0);
    m_exc = '0;
    m_int = '0;
  endtask

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    e.code     = cause(pipe[2]);
    e.bd       = pipe[2].bd;
    e.pc       = pipe[2].pc;
    e.exl      = pipe[2].eret && (e.code == 0) && !s.req;
    e.flush    = s.req || e.exl;
    e.redirect = e.flush;
    e.rpc      = s.req ? HANDLER : s.epc;
    e.ec       = m_exc;
    e.ic       = m_int;
    return e;
  endfunction

  task automatic model_step(input stim_t s, input exp_t e);
    instr_t dn, en, mn;
    if (e.flush) begin
      for (int i = 0; i < 3; i++) pipe[i] = blank(e.rpc, 0);
    end else begin
      mn = pipe[1];
      mn.ov = s.ov; mn.adel = s.adel; mn.ades = s.ades;
      if (s.stall) begin
        en = blank(pipe[0].pc, pipe[0].bd);
        dn = pipe[0];
      end else begin
        en = pipe[0];
        en.ri = s.ri; en.sys = s.sys; en.bp = s.bp; en.eret = s.eret;
        dn = blank(s.pc_f, s.jump);
        dn.f_adel = (s.pc_f[1:0] != 2'b00);
      end
      pipe[0] = dn; pipe[1] = en; pipe[2] = mn;
    end
    if (s.req) begin
      if (e.code != 0) begin
        if (m_exc != 16'hFFFF) m_exc = m_exc + 16'd1;
      end else begin
        if (m_int != 16'hFFFF) m_int = m_int + 16'd1;
      end
    end
  endtask

  function automatic stim_t nop(input logic [31:0] pc);
    stim_t s;
    s.stall = 0; s.pc_f = pc; s.ri = 0; s.sys = 0; s.bp = 0; s.eret = 0;
    s.jump = 0; s.ov = 0; s.adel = 0; s.ades = 0; s.req = 0; s.epc = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    logic [31:0] p;
    p = $urandom();
    p[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
    s.pc_f  = p;
    s.stall = ($urandom_range(0, 4) == 0);
    s.ri    = ($urandom_range(0, 7) == 0);
    s.sys   = ($urandom_range(0, 7) == 0);
    s.bp    = ($urandom_range(0, 7) == 0);
    s.eret  = ($urandom_range(0, 5) == 0);
    s.jump  = ($urandom_range(0, 3) == 0);
    s.ov    = ($urandom_range(0, 9) == 0);
    s.adel  = ($urandom_range(0, 9) == 0);
    s.ades  = ($urandom_range(0, 9) == 0);
    s.req   = ($urandom_range(0, 9) == 0);
    s.epc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    stall_D = s.stall; pc_F = s.pc_f;
    ri_D = s.ri; syscall_D = s.sys; break_D = s.bp; eret_D = s.eret; jump_D = s.jump;
    ov_E = s.ov; adel_E = s.adel; ades_E = s.ades;
    req = s.req; epc = s.epc;
  endtask

  // One clock: drive, queue the expectation, advance the model on the edge
  task automatic cycle(input stim_t s);
    exp_t e;
    drive(s);
    e = predict(s);
    sbq.push_back(e);
    @(posedge clk);
    if (resetn) model_step(s, e);
    #1;
  endtask

  // Assert reset while a CP0 request is flushing; CP0 drops req under reset too
  task automatic rst_pulse(input stim_t s);
    exp_t e;
    s.req = 1;
    drive(s);
    #2;
    resetn = 1'b0;
    s.req = 0;
    drive(s);
    model_reset();
    e = predict(s);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("ExcCode_M", 32'(ExcCode_M), 32'(mon_e.code));
        chk("bd_M",      32'(bd_M),      32'(mon_e.bd));
        chk("pc_M",      pc_M,           mon_e.pc);
        chk("EXLClr",    32'(EXLClr),    32'(mon_e.exl));
        chk("flush",     32'(flush),     32'(mon_e.flush));
        chk("redirect",  32'(redirect),  32'(mon_e.redirect));
        if (mon_e.redirect) chk("redirect_pc", redirect_pc, mon_e.rpc);
`ifdef EXC_PERF_CNT_EN
        chk("exc_cnt", 32'(exc_cnt), 32'(mon_e.ec));
        chk("int_cnt", 32'(int_cnt), 32'(mon_e.ic));
`endif
      end
    end
  end

  initial begin
    stim_t s;
    resetn = 1'b0;
    drive(nop(RST_PC));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle(nop(RST_PC));
    cycle(nop(RST_PC));
    resetn = 1'b1;

    // Misaligned fetch reaches M after three edges, then CP0 takes it
    cycle(nop(32'hBFC0_0102));
    cycle(nop(32'hBFC0_0108));
    cycle(nop(32'hBFC0_010C));
    s = nop(32'hBFC0_0110); s.req = 1; cycle(s);

    // RI outranks Syscall in the same decode
    cycle(nop(32'h0000_1000));
    s = nop(32'h0000_1004); s.ri = 1; s.sys = 1; cycle(s);
    cycle(nop(32'h0000_1008));
    cycle(nop(32'h0000_100C));

    // Overflow in a delay slot
    cycle(nop(32'h0000_2000));
    s = nop(32'h0000_2004); s.jump = 1; cycle(s);
    cycle(nop(32'h0000_2008));
    s = nop(32'h0000_200C); s.ov = 1; cycle(s);
    cycle(nop(32'h0000_2010));

    // Two-cycle stall, interrupt lands on the bubble in M
    cycle(nop(32'h0000_4000));
    s = nop(32'h0000_4004); s.stall = 1; cycle(s);
    cycle(s);
    s = nop(32'h0000_4004); s.req = 1; cycle(s);

    // ERET retiring alone, then colliding with a request
    cycle(nop(32'h0000_5000));
    s = nop(32'h0000_5004); s.eret = 1; cycle(s);
    cycle(nop(32'h0000_5008));
    s = nop(32'h0000_500C); s.epc = 32'h0000_3000; cycle(s);
    cycle(nop(32'h0000_6000));
    s = nop(32'h0000_6004); s.eret = 1; cycle(s);
    cycle(nop(32'h0000_6008));
    s = nop(32'h0000_600C); s.epc = 32'h0000_3000; s.req = 1; cycle(s);

    // Reset in the middle of a flush
    rst_pulse(nop(32'h0000_7000));
    cycle(nop(32'h0000_7004));

    // Random traffic with occasional mid-flush resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) rst_pulse(rnd());
      else cycle(rnd());
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
